// File: rtl/gps_pkg.sv
// Shared widths and the 32-point carrier table for the correlator channel.
// Each table entry packs {cos, sin} as two 9-bit two's-complement values scaled by 255.
package gps_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int LUT_W     = 9;
    localparam int PHASE_W   = 32;
    localparam int LUT_DEPTH = 32;
    localparam int LUT_AW    = 5;
    localparam int PROD_W    = SAMPLE_W + LUT_W;
    localparam int SUM_W     = PROD_W + 1;

    typedef logic [2*LUT_W-1:0] cs_t;

    localparam cs_t CARRIER_LUT [LUT_DEPTH] = '{
        { 9'sd255,   9'sd0  }, { 9'sd250,   9'sd50 }, { 9'sd236,   9'sd98 }, { 9'sd212,   9'sd142},
        { 9'sd180,   9'sd180}, { 9'sd142,   9'sd212}, { 9'sd98,    9'sd236}, { 9'sd50,    9'sd250},
        { 9'sd0,     9'sd255}, {-9'sd50,    9'sd250}, {-9'sd98,    9'sd236}, {-9'sd142,   9'sd212},
        {-9'sd180,   9'sd180}, {-9'sd212,   9'sd142}, {-9'sd236,   9'sd98 }, {-9'sd250,   9'sd50 },
        {-9'sd255,   9'sd0  }, {-9'sd250,  -9'sd50 }, {-9'sd236,  -9'sd98 }, {-9'sd212,  -9'sd142},
        {-9'sd180,  -9'sd180}, {-9'sd142,  -9'sd212}, {-9'sd98,   -9'sd236}, {-9'sd50,   -9'sd250},
        { 9'sd0,    -9'sd255}, { 9'sd50,   -9'sd250}, { 9'sd98,   -9'sd236}, { 9'sd142,  -9'sd212},
        { 9'sd180,  -9'sd180}, { 9'sd212,  -9'sd142}, { 9'sd236,  -9'sd98 }, { 9'sd250,  -9'sd50 }
    };

endpackage

// File: rtl/carrier_nco.sv
// Phase accumulator driving the carrier table; {cos, sin} is registered on each advance,
// so the carrier for a sample appears alongside that sample one cycle later.
module carrier_nco
    import gps_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    input  logic [PHASE_W-1:0] freq,
    output logic [LUT_W-1:0]   cos_out,
    output logic [LUT_W-1:0]   sin_out
);

    logic [PHASE_W-1:0] phase_reg;
    cs_t                cs_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
            cs_reg    <= '0;
        end else if (clear) begin
            phase_reg <= '0;
        end else if (advance) begin
            // Table lookup uses the phase before this sample's increment.
            cs_reg    <= CARRIER_LUT[phase_reg[PHASE_W-1 -: LUT_AW]];
            phase_reg <= phase_reg + freq;
        end
    end

    assign cos_out = cs_reg[2*LUT_W-1:LUT_W];
    assign sin_out = cs_reg[LUT_W-1:0];

endmodule

// File: rtl/sat_corr_chan.sv
// Doppler wipe-off and integrate-and-dump for one tracked satellite:
// NCO + table (S1), conjugate complex multiply (S2), accumulate/dump (S3), valid/ready output.
module sat_corr_chan
    import gps_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clear,
    input  logic             in_valid,
    input  logic [15:0]      real_in,
    input  logic [15:0]      imag_in,
    input  logic [31:0]      freq,
    input  logic [15:0]      dump_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_i,
    output logic [ACC_W-1:0] out_q,
    output logic             overrun
);

    logic accept;
    assign accept = in_valid & ~sync_clear;

    logic [15:0] cnt_reg, len_reg, len_eff;
    logic        last;

    always_comb begin
        len_eff = len_reg;
        if (cnt_reg == 16'd0) begin
            len_eff = (dump_len == 16'd0) ? 16'd1 : dump_len;
        end
        last = (cnt_reg == len_eff - 16'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            len_reg <= '0;
        end else if (sync_clear) begin
            cnt_reg <= '0;
        end else if (accept) begin
            if (cnt_reg == 16'd0) begin
                len_reg <= len_eff;
            end
            cnt_reg <= last ? 16'd0 : cnt_reg + 16'd1;
        end
    end

    logic [LUT_W-1:0] nco_cos, nco_sin;

    carrier_nco u_nco (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (sync_clear),
        .advance (accept),
        .freq    (freq),
        .cos_out (nco_cos),
        .sin_out (nco_sin)
    );

    logic                       s1_valid, s1_last;
    logic signed [SAMPLE_W-1:0] s1_re, s1_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= last;
                s1_re   <= $signed(real_in);
                s1_im   <= $signed(imag_in);
            end
        end
    end

    logic signed [LUT_W-1:0]  c_s, s_s;
    logic signed [PROD_W-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [SUM_W-1:0]  sum_i, sum_q;

    assign c_s   = $signed(nco_cos);
    assign s_s   = $signed(nco_sin);
    assign p_rc  = PROD_W'(s1_re) * PROD_W'(c_s);
    assign p_is  = PROD_W'(s1_im) * PROD_W'(s_s);
    assign p_ic  = PROD_W'(s1_im) * PROD_W'(c_s);
    assign p_rs  = PROD_W'(s1_re) * PROD_W'(s_s);
    // Multiply by the conjugate carrier: (r + jq)(cos - j sin).
    assign sum_i = SUM_W'(p_rc) + SUM_W'(p_is);
    assign sum_q = SUM_W'(p_ic) - SUM_W'(p_rs);

    logic                    s2_valid, s2_last;
    logic signed [SUM_W-1:0] s2_i, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_i     <= '0;
            s2_q     <= '0;
        end else begin
            s2_valid <= s1_valid & ~sync_clear;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_i    <= sum_i;
                s2_q    <= sum_q;
            end
        end
    end

    logic signed [ACC_W-1:0] acc_i_reg, acc_q_reg, next_i, next_q;
    logic [ACC_W-1:0]        out_i_reg, out_q_reg;
    logic                    out_valid_reg, overrun_reg, dump;

    assign next_i = acc_i_reg + ACC_W'(s2_i);
    assign next_q = acc_q_reg + ACC_W'(s2_q);
    assign dump   = s2_valid & s2_last & ~sync_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i_reg     <= '0;
            acc_q_reg     <= '0;
            out_i_reg     <= '0;
            out_q_reg     <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            overrun_reg <= dump & out_valid_reg & ~out_ready;
            if (sync_clear) begin
                acc_i_reg <= '0;
                acc_q_reg <= '0;
            end else if (s2_valid) begin
                acc_i_reg <= s2_last ? '0 : next_i;
                acc_q_reg <= s2_last ? '0 : next_q;
            end
            // A dump landing in the consume cycle replaces the result rather than clearing valid.
            if (dump) begin
                out_i_reg     <= next_i;
                out_q_reg     <= next_q;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_i     = out_i_reg;
    assign out_q     = out_q_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_sat_corr_chan.sv
// Bench for sat_corr_chan: a sample-level model pushes each expected dump to a queue tagged
// with its due cycle; a per-cycle monitor pops and checks the output register and handshake.
module tb_sat_corr_chan;

    logic        clk, rst_n, sync_clear, in_valid, out_valid, out_ready, overrun;
    logic [15:0] real_in, imag_in, dump_len;
    logic [31:0] freq;
    logic [47:0] out_i, out_q;

    sat_corr_chan #(.ACC_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clear(sync_clear), .in_valid(in_valid),
        .real_in(real_in), .imag_in(imag_in), .freq(freq), .dump_len(dump_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [47:0] i;
        logic [47:0] q;
    } exp_t;

    typedef struct {
        logic [31:0] freq;
        int          len;
        int          n;
        int          re [4];
        int          im [4];
        longint      ei;
        longint      eq;
    } vec_t;

    exp_t        sb [$];
    vec_t        vecs [6];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lut_c [32];
    int          lut_s [32];

    logic [31:0] b_phase;
    int          b_cnt, b_len;
    longint      b_acc_i, b_acc_q;

    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [47:0] m_i     = '0;
    logic [47:0] m_q     = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        b_phase = '0;
        b_cnt   = 0;
        b_len   = 0;
        b_acc_i = 0;
        b_acc_q = 0;
    endtask

    // Drives one cycle of input (from a negedge) and advances the sample model.
    task automatic step(input bit v, input int re, input int im, input bit clr);
        int     k;
        longint wi, wq;
        exp_t   e;
        in_valid   = v;
        real_in    = re[15:0];
        imag_in    = im[15:0];
        sync_clear = clr;
        if (clr) begin
            model_reset();
            while (sb.size() > 0 && sb[sb.size()-1].due >= cyc + 1) void'(sb.pop_back());
        end else if (v) begin
            k  = int'(b_phase[31:27]);
            wi = longint'(re * lut_c[k] + im * lut_s[k]);
            wq = longint'(im * lut_c[k] - re * lut_s[k]);
            if (b_cnt == 0) b_len = (dump_len == 16'd0) ? 1 : int'(dump_len);
            b_acc_i += wi;
            b_acc_q += wq;
            if (b_cnt == b_len - 1) begin
                e.due = cyc + 3;
                e.i   = b_acc_i[47:0];
                e.q   = b_acc_q[47:0];
                sb.push_back(e);
                b_acc_i = 0;
                b_acc_q = 0;
                b_cnt   = 0;
            end else begin
                b_cnt++;
            end
            b_phase = b_phase + freq;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic add_vec(input int idx, input logic [31:0] f, input int len, input int n,
                           input int r0, input int i0, input int r1, input int i1,
                           input int r2, input int i2, input int r3, input int i3,
                           input longint ei, input longint eq);
        vecs[idx].freq = f;   vecs[idx].len = len;  vecs[idx].n = n;
        vecs[idx].re[0] = r0; vecs[idx].im[0] = i0; vecs[idx].re[1] = r1; vecs[idx].im[1] = i1;
        vecs[idx].re[2] = r2; vecs[idx].im[2] = i2; vecs[idx].re[3] = r3; vecs[idx].im[3] = i3;
        vecs[idx].ei = ei;    vecs[idx].eq = eq;
    endtask

    task automatic run_vec(input int idx);
        logic [47:0] ei, eq;
        freq      = vecs[idx].freq;
        dump_len  = 16'(vecs[idx].len);
        out_ready = 1'b0;
        step(1'b0, 0, 0, 1'b1);
        for (int j = 0; j < vecs[idx].n; j++) step(1'b1, vecs[idx].re[j], vecs[idx].im[j], 1'b0);
        idle(4);
        ei = vecs[idx].ei[47:0];
        eq = vecs[idx].eq[47:0];
        chk($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("vec%0d_i", idx), 64'(out_i), 64'(ei));
        chk($sformatf("vec%0d_q", idx), 64'(out_q), 64'(eq));
        $display("vec %0d: freq=%0h len=%0d n=%0d out_i=%0d out_q=%0d",
                 idx, vecs[idx].freq, vecs[idx].len, vecs[idx].n, $signed(out_i), $signed(out_q));
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(1);
    endtask

    // Per-cycle monitor: updates the expected output register at each edge, checks #1 later.
    initial begin
        exp_t e;
        logic rdy;
        forever begin
            @(posedge clk);
            cyc++;
            rdy = out_ready;
            if (!rst_n) begin
                m_valid = 1'b0; m_ovr = 1'b0; m_i = '0; m_q = '0;
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e       = sb.pop_front();
                m_ovr   = m_valid & ~rdy;
                m_valid = 1'b1;
                m_i     = e.i;
                m_q     = e.q;
            end else begin
                m_ovr = 1'b0;
                if (rdy) m_valid = 1'b0;
            end
            #1;
            chk("mon_out_valid", 64'(out_valid), 64'(m_valid));
            chk("mon_overrun", 64'(overrun), 64'(m_ovr));
            chk("mon_out_i", 64'(out_i), 64'(m_i));
            chk("mon_out_q", 64'(out_q), 64'(m_q));
        end
    end

    initial begin
        logic [47:0] exp_q48;
        real pi_r;
        pi_r = 3.14159265358979;
        for (int k = 0; k < 32; k++) begin
            lut_c[k] = $rtoi($floor(255.0 * $cos(2.0 * pi_r * k / 32.0) + 0.5));
            lut_s[k] = $rtoi($floor(255.0 * $sin(2.0 * pi_r * k / 32.0) + 0.5));
        end
        add_vec(0, 32'h0000_0000, 4, 4,  100, 0,  100, 0,  100, 0,  100, 0,  102000, 0);
        add_vec(1, 32'h4000_0000, 4, 4,  100, 0,  100, 0,  100, 0,  100, 0,  0, 0);
        add_vec(2, 32'h4000_0000, 4, 4,  255, 0,  0, 255,  -255, 0,  0, -255,  260100, 0);
        add_vec(3, 32'h0000_0000, 2, 2,  -300, 7,  -300, 7,  0, 0,  0, 0,  -153000, 3570);
        add_vec(4, 32'h0800_0000, 4, 4,  0, 100,  0, 100,  0, 100,  0, 100,  29000, 95300);
        add_vec(5, 32'h0000_0000, 0, 1,  10, 20,  0, 0,  0, 0,  0, 0,  2550, 5100);

        model_reset();
        rst_n = 1'b1; in_valid = 1'b0; sync_clear = 1'b0; real_in = '0; imag_in = '0;
        freq = '0; dump_len = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_out_i", 64'(out_i), 64'd0);
        chk("reset_out_q", 64'(out_q), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        for (int v = 0; v < 6; v++) run_vec(v);

        // Back-to-back dumps with the consumer stalled: every later dump overruns.
        freq = '0; dump_len = 16'd1; out_ready = 1'b0;
        step(1'b0, 0, 0, 1'b1);
        for (int k = 1; k <= 5; k++) step(1'b1, k * 10, -k, 1'b0);
        idle(3);
        exp_q48 = -48'sd1275;
        chk("hs_held_valid", 64'(out_valid), 64'd1);
        chk("hs_newest_i", 64'(out_i), 64'd12750);
        chk("hs_newest_q", 64'(out_q), 64'(exp_q48));
        $display("handshake stall: out_i=%0d out_q=%0d", $signed(out_i), $signed(out_q));
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) out_ready = 1'b1;
            step(1'b1, 7 + k, 3, 1'b0);
            if (k == 5) begin
                chk("hs_simul_no_overrun", 64'(overrun), 64'd0);
                chk("hs_simul_valid", 64'(out_valid), 64'd1);
                $display("handshake consume with dump: valid=%0b overrun=%0b", out_valid, overrun);
            end
        end
        idle(4);
        chk("hs_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // sync_clear mid-period: the sample in the clear cycle is dropped, phase restarts.
        freq = 32'h0800_0000; dump_len = 16'd4;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 1000, 1000, 1'b0);
        step(1'b1, 1000, 1000, 1'b0);
        step(1'b1, 1000, 1000, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 0, 100, 1'b0);
        idle(4);
        chk("clr_valid", 64'(out_valid), 64'd1);
        chk("clr_i", 64'(out_i), 64'd29000);
        chk("clr_q", 64'(out_q), 64'd95300);
        $display("sync_clear: out_i=%0d out_q=%0d", $signed(out_i), $signed(out_q));
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;

        // Asynchronous reset while a result is pending.
        freq = '0; dump_len = 16'd1;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 100, 0, 1'b0);
        idle(4);
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        model_reset();
        m_valid = 1'b0; m_ovr = 1'b0; m_i = '0; m_q = '0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_i", 64'(out_i), 64'd0);
        chk("rst_async_q", 64'(out_q), 64'd0);
        $display("async reset: valid=%0b out_i=%0d", out_valid, $signed(out_i));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        run_vec(0);
        run_vec(4);

        idle(5);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
